muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width; legal values are even integers >= 4.
REQ-002 The block SHALL have parameter SIGNED_EN, default 1; when 0, signed ops are treated as their unsigned forms.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request a new operation; sampled only in IDLE.
REQ-006 op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 src_a, src_b  input  WIDTH each  operands; for DIV, src_a is the dividend.
REQ-008 flush  input  1  abort any in-flight operation.
REQ-009 hi_we, lo_we  input  1 each  direct HI/LO write (MTHI/MTLO).
REQ-010 hilo_wdata  input  WIDTH  data for the direct write.
REQ-011 busy  output  1  operation in progress.
REQ-012 stall  output  1  combinational: busy OR (IDLE AND start AND NOT flush); the pipeline holds while high.
REQ-013 done  output  1  one-cycle pulse marking new HI/LO.
REQ-014 hi, lo  output  WIDTH each  architectural HI/LO registers.

Function
REQ-015 The FSM SHALL have states IDLE, MUL, DIV and FIN.
REQ-016 In IDLE, start=1 with flush=0 SHALL latch the operands and op, load a counter with WIDTH, and enter MUL (op 0x) or DIV (op 1x).
REQ-017 Signed ops SHALL convert operands to magnitudes at latch time and record result signs: product/quotient sign = a[MSB]^b[MSB]; remainder sign = a[MSB].
REQ-018 MUL SHALL perform one radix-2 shift-add step per cycle on a 2*WIDTH accumulator, decrement the counter, and go to FIN when the counter reaches 1.
REQ-019 DIV SHALL perform one restoring shift-subtract step per cycle, decrement the counter, and go to FIN when the counter reaches 1.
REQ-020 FIN SHALL apply sign correction and write HI/LO on the edge leaving FIN, assert done for the following cycle, then return to IDLE.
REQ-021 Result mapping: MUL gives HI = upper WIDTH bits and LO = lower WIDTH bits of the 2*WIDTH product; DIV gives LO = quotient and HI = remainder.
REQ-022 Latency: start is accepted at edge E0; busy=1 for cycles 1..WIDTH+1; the new hi/lo and done=1 are visible in cycle WIDTH+2, with busy=0 in that cycle.
REQ-023 Divide by zero SHALL give HI = src_a unchanged and LO = all ones, for both DIV and DIVU, with the same latency.
REQ-024 DIV of the most negative value by -1 SHALL give LO = most negative value and HI = 0.
REQ-025 start while busy SHALL be ignored; no queuing.
REQ-026 flush while busy SHALL return the FSM to IDLE on the next edge, leave HI/LO unchanged, and suppress done.
REQ-027 flush and start together in IDLE SHALL start nothing.
REQ-028 hi_we/lo_we SHALL write hilo_wdata only in IDLE and are ignored while busy.
REQ-029 If a direct write coincides with the FIN write edge, the FIN result SHALL take priority.
REQ-030 done SHALL never be high for two consecutive cycles.

Reset
REQ-031 When rst=0 at a rising edge, the block SHALL enter IDLE and set hi=0, lo=0, busy=0 and done=0.
REQ-032 Reset SHALL abort any in-flight operation without writing a result.
REQ-033 stall SHALL be 0 in the cycle after reset, provided start=0.

Verification
REQ-034 WIDTH=32, MULT a=-3, b=5 -> in cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFF1, done=1; busy=1 in cycles 1..33.
REQ-035 DIVU 100/7 -> lo=14, hi=2; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-036 DIV 0x12345678/0 -> hi=0x12345678, lo=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 Preload hi=0xAA via hi_we, start MULTU, flush in cycle 10 -> busy=0 in cycle 11, done never asserted, hi=0xAA.
REQ-038 rst=0 in cycle 5 of a DIVU -> hi=lo=0, busy=0, no done; a following MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-039 WIDTH=8 build, MULT -128*-128 -> hi=0x40, lo=0x00 in cycle 10.

Source files
------------

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 multiply / restoring divide unit with HI/LO registers
module muldiv_unit #(
   parameter int WIDTH     = 32,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             flush,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] hilo_wdata,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

   state_t               state, state_next;
   logic [CW-1:0]        cnt;
   logic [2*WIDTH-1:0]   acc;
   logic [WIDTH-1:0]     opnd;
   logic                 neg_q, neg_r, is_div, div_zero;

   logic                 accept, op_signed;
   logic [WIDTH-1:0]     mag_a, mag_b;
   logic [WIDTH:0]       mul_sum, rem_sh, div_diff;
   logic [2*WIDTH-1:0]   mul_acc, div_acc, prod;
   logic [WIDTH-1:0]     quot, rem;

   assign accept    = (state == IDLE) && start && !flush;
   assign op_signed = SIGNED_EN && !op[0];
   assign mag_a     = (op_signed && src_a[WIDTH-1]) ? -src_a : src_a;
   assign mag_b     = (op_signed && src_b[WIDTH-1]) ? -src_b : src_b;

   assign busy  = (state != IDLE);
   assign stall = busy || accept;

   // Multiply: acc holds {partial product, remaining multiplier bits}
   assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
   assign mul_acc = {mul_sum, acc[WIDTH-1:1]};

   // Divide: acc holds {partial remainder, dividend bits shifting into quotient}
   assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign div_diff = rem_sh - {1'b0, opnd};
   assign div_acc  = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

   assign prod = neg_q ? -acc : acc;
   assign quot = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = op[1] ? DIV : MUL;
         MUL:     if (cnt == CW'(1)) state_next = FIN;
         DIV:     if (cnt == CW'(1)) state_next = FIN;
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (flush && state != IDLE) state_next = IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         hi       <= '0;
         lo       <= '0;
         done     <= 1'b0;
         cnt      <= '0;
         acc      <= '0;
         opnd     <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         is_div   <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (hi_we) hi <= hilo_wdata;
               if (lo_we) lo <= hilo_wdata;
               if (accept) begin
                  cnt      <= CW'(WIDTH);
                  is_div   <= op[1];
                  neg_q    <= op_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                  neg_r    <= op_signed && src_a[WIDTH-1];
                  div_zero <= (src_b == '0);
                  if (op[1]) begin
                     acc  <= {{WIDTH{1'b0}}, mag_a};
                     opnd <= mag_b;
                  end else begin
                     acc  <= {{WIDTH{1'b0}}, mag_b};
                     opnd <= mag_a;
                  end
               end
            end
            MUL: begin
               acc <= mul_acc;
               cnt <= cnt - CW'(1);
            end
            DIV: begin
               acc <= div_acc;
               cnt <= cnt - CW'(1);
            end
            FIN: begin
               // Result write outranks any direct HI/LO write on this edge
               if (!flush) begin
                  if (is_div) begin
                     hi <= rem;
                     lo <= div_zero ? '1 : quot;
                  end else begin
                     hi <= prod[2*WIDTH-1:WIDTH];
                     lo <= prod[WIDTH-1:0];
                  end
                  done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
